// File: rtl/jtgng_ioctl_tx_pkg.sv
// Shared types and widths for the ROM download transmitter.
package jtgng_ioctl_tx_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_WAITB = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5
    } dl_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ioctl_beat_t;

endpackage

// File: rtl/jtgng_dl_delay.sv
// Loadable down-counter with a zero flag; shared by the lead-in, gap and tail timers.
module jtgng_dl_delay
    import jtgng_ioctl_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/jtgng_ioctl_tx.sv
// ROM download transmitter: replays a valid/ready byte stream as paced ioctl_wr strobes
// inside a downloading window with lead-in and tail delays.
module jtgng_ioctl_tx
    import jtgng_ioctl_tx_pkg::*;
#(
    parameter int unsigned WR_GAP   = 8,
    parameter int unsigned LEAD_DLY = 16,
    parameter int unsigned TAIL_DLY = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [21:0] length,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        downloading,
    output logic [21:0] ioctl_addr,
    output logic [7:0]  ioctl_data,
    output logic        ioctl_wr,
    output logic        busy,
    output logic        done
);

    // Each timed state lasts load value + 1 cycles
    localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(LEAD_DLY - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((WR_GAP > 2) ? WR_GAP - 3 : 0);
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(TAIL_DLY - 1);
    localparam bit               HAS_GAP = (WR_GAP > 2);

    dl_state_e         state, state_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] remaining;
    ioctl_beat_t       beat_q;
    logic              ready_q;
    logic              dly_load;
    logic [CNT_W-1:0]  dly_val;
    logic              dly_zero;
    logic              go_tail;
    logic              hs;

    jtgng_dl_delay u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .zero_c   (dly_zero)
    );

    // A byte offered in the same cycle as abort is refused
    assign s_ready    = ready_q & ~abort;
    assign hs         = s_valid & s_ready;
    assign ioctl_addr = beat_q.addr;
    assign ioctl_data = beat_q.data;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        dly_load = 1'b0;
        dly_val  = '0;
        go_tail  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LEAD;
                    dly_load = 1'b1;
                    dly_val  = LEAD_LD;
                end
            end
            ST_LEAD, ST_GAP: begin
                if (abort)
                    go_tail = 1'b1;
                else if (dly_zero) begin
                    if (remaining != '0)
                        state_d = ST_WAITB;
                    else
                        go_tail = 1'b1;
                end
            end
            ST_WAITB: begin
                if (abort)
                    go_tail = 1'b1;
                else if (hs)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // remaining is decremented on this edge, so compare against 1
                if (abort)
                    go_tail = 1'b1;
                else if (HAS_GAP) begin
                    state_d  = ST_GAP;
                    dly_load = 1'b1;
                    dly_val  = GAP_LD;
                end else if (remaining != ADDR_W'(1))
                    state_d = ST_WAITB;
                else
                    go_tail = 1'b1;
            end
            ST_TAIL: begin
                if (dly_zero)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (go_tail) begin
            state_d  = ST_TAIL;
            dly_load = 1'b1;
            dly_val  = TAIL_LD;
        end
    end

    // Outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            downloading <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ioctl_wr    <= 1'b0;
            ready_q     <= 1'b0;
            beat_q      <= '0;
            addr_cnt    <= '0;
            remaining   <= '0;
        end else begin
            downloading <= (state_d != ST_IDLE);
            busy        <= (state_d != ST_IDLE);
            done        <= (state == ST_TAIL) && (state_d == ST_IDLE);
            ioctl_wr    <= (state_d == ST_WRITE);
            ready_q     <= (state_d == ST_WAITB);
            if (state == ST_IDLE && start) begin
                remaining <= length;
                addr_cnt  <= '0;
            end
            if (state == ST_WRITE) begin
                addr_cnt  <= addr_cnt + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
            end
            if (hs) begin
                beat_q.addr <= addr_cnt;
                beat_q.data <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_jtgng_ioctl_tx.sv
// Self-checking bench for jtgng_ioctl_tx: one instance with an 8-cycle write gap, one with a 2-cycle gap.
module tb_jtgng_ioctl_tx;

    localparam int unsigned A_GAP = 8, A_LEAD = 16, A_TAIL = 16;
    localparam int unsigned B_GAP = 2, B_LEAD = 3,  B_TAIL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // instance A
    logic        a_rst_n, a_start, a_abort, a_s_valid;
    logic [21:0] a_length;
    logic [7:0]  a_s_data;
    logic        a_s_ready, a_downloading, a_wr, a_busy, a_done;
    logic [21:0] a_addr;
    logic [7:0]  a_data;
    // instance B
    logic        b_rst_n, b_start, b_abort, b_s_valid;
    logic [21:0] b_length;
    logic [7:0]  b_s_data;
    logic        b_s_ready, b_downloading, b_wr, b_busy, b_done;
    logic [21:0] b_addr;
    logic [7:0]  b_data;

    jtgng_ioctl_tx #(.WR_GAP(A_GAP), .LEAD_DLY(A_LEAD), .TAIL_DLY(A_TAIL)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort), .length(a_length),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .downloading(a_downloading), .ioctl_addr(a_addr), .ioctl_data(a_data),
        .ioctl_wr(a_wr), .busy(a_busy), .done(a_done)
    );

    jtgng_ioctl_tx #(.WR_GAP(B_GAP), .LEAD_DLY(B_LEAD), .TAIL_DLY(B_TAIL)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort), .length(b_length),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .downloading(b_downloading), .ioctl_addr(b_addr), .ioctl_data(b_data),
        .ioctl_wr(b_wr), .busy(b_busy), .done(b_done)
    );

    // scoreboards and observation counters
    logic [29:0] a_exp_q[$];
    logic [29:0] b_exp_q[$];
    int a_wr_cyc[$];
    int b_wr_cyc[$];
    int a_wr_cnt, a_dl_cnt, a_ready_cnt, a_done_cnt, a_done_cyc, a_fall_cnt, a_fall_cyc;
    int b_wr_cnt, b_dl_cnt, b_done_cnt;
    logic a_dl_prev = 1'b0;
    int a_start_cyc, a_abort_cyc, b_start_cyc;
    logic [7:0] a_src [0:7];
    logic [7:0] b_src [0:7];

    always @(negedge clk) begin
        logic [29:0] e;
        if (a_downloading) a_dl_cnt++;
        if (a_s_ready) a_ready_cnt++;
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        if (a_dl_prev && !a_downloading) begin a_fall_cnt++; a_fall_cyc = cyc; end
        a_dl_prev = a_downloading;
        if (a_wr) begin
            a_wr_cnt++;
            a_wr_cyc.push_back(cyc);
            checks++;
            if (a_exp_q.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_wr: got addr=%0h data=%02h, required no write", a_addr, a_data);
            end else begin
                e = a_exp_q.pop_front();
                if ({a_addr, a_data} !== e) begin
                    errors++;
                    $display("FAIL a_wr_beat: got addr=%0h data=%02h, required addr=%0h data=%02h",
                             a_addr, a_data, e[29:8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [29:0] e;
        if (b_downloading) b_dl_cnt++;
        if (b_done) b_done_cnt++;
        if (b_wr) begin
            b_wr_cnt++;
            b_wr_cyc.push_back(cyc);
            checks++;
            if (b_exp_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_wr: got addr=%0h data=%02h, required no write", b_addr, b_data);
            end else begin
                e = b_exp_q.pop_front();
                if ({b_addr, b_data} !== e) begin
                    errors++;
                    $display("FAIL b_wr_beat: got addr=%0h data=%02h, required addr=%0h data=%02h",
                             b_addr, b_data, e[29:8], e[7:0]);
                end
            end
        end
    end

    task automatic clear_a();
        a_exp_q.delete(); a_wr_cyc.delete();
        a_wr_cnt = 0; a_dl_cnt = 0; a_ready_cnt = 0; a_done_cnt = 0;
        a_done_cyc = -1; a_fall_cnt = 0; a_fall_cyc = -2; a_abort_cyc = -100;
    endtask

    task automatic clear_b();
        b_exp_q.delete(); b_wr_cyc.delete();
        b_wr_cnt = 0; b_dl_cnt = 0; b_done_cnt = 0;
    endtask

    // Runs one transfer on instance A until done (bounded); optional stall and abort points.
    task automatic drive_a(input int len, input int stall_idx, input int stall_len,
                           input int abort_idx, input bit start_abort);
        int  i = 0;
        int  stall = 0;
        bit  stalled = 0;
        bit  aborted = 0;
        bit  fin = 0;
        @(posedge clk); #1;
        a_start = 1'b1; a_abort = start_abort; a_length = 22'(len); a_start_cyc = cyc;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(posedge clk); #1;
            a_start = 1'b0; a_abort = 1'b0; a_s_valid = 1'b0;
            if (a_done) fin = 1;
            else if (!aborted) begin
                if (i == stall_idx && !stalled) begin stall = stall_len; stalled = 1; end
                if (stall > 0) stall--;
                else if (i < len) begin
                    a_s_valid = 1'b1; a_s_data = a_src[i];
                    #1;
                    if (i == abort_idx && a_s_ready) begin
                        a_abort = 1'b1; a_abort_cyc = cyc; aborted = 1;
                        #1;
                        checks++;
                        if (a_s_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL abort_refuse: s_ready=%b, required 0", a_s_ready);
                        end
                    end else if (a_s_ready) begin
                        a_exp_q.push_back({22'(i), a_src[i]});
                        i++;
                    end
                end
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL a_timeout: done not seen, required done within 3000 cycles");
        end
        a_s_valid = 1'b0; a_abort = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        a_rst_n = 0; a_start = 0; a_abort = 0; a_length = '0; a_s_data = '0; a_s_valid = 0;
        b_rst_n = 0; b_start = 0; b_abort = 0; b_length = '0; b_s_data = '0; b_s_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_downloading, a_addr, a_data, a_wr, a_busy, a_done, a_s_ready} !== 36'd0) begin
            errors++;
            $display("FAIL a_reset_outputs: dl=%b addr=%0h data=%02h wr=%b busy=%b done=%b rdy=%b, required all 0",
                     a_downloading, a_addr, a_data, a_wr, a_busy, a_done, a_s_ready);
        end
        checks++;
        if ({b_downloading, b_addr, b_data, b_wr, b_busy, b_done, b_s_ready} !== 36'd0) begin
            errors++;
            $display("FAIL b_reset_outputs: dl=%b addr=%0h data=%02h wr=%b busy=%b done=%b rdy=%b, required all 0",
                     b_downloading, b_addr, b_data, b_wr, b_busy, b_done, b_s_ready);
        end
        a_rst_n = 1; b_rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_a();
        a_src[0] = 8'hA1; a_src[1] = 8'hB2; a_src[2] = 8'hC3; a_src[3] = 8'hD4;
        drive_a(4, -1, 0, -1, 1'b0);
        checks++;
        if (a_wr_cnt != 4) begin errors++; $display("FAIL basic_wr_count: got %0d, required 4", a_wr_cnt); end
        checks++;
        if (a_exp_q.size() != 0) begin errors++; $display("FAIL basic_pending: got %0d left, required 0", a_exp_q.size()); end
        if (a_wr_cyc.size() == 4) begin
            checks++;
            if (a_wr_cyc[0] != a_start_cyc + int'(A_LEAD) + 2) begin
                errors++;
                $display("FAIL basic_first_latency: got %0d, required %0d", a_wr_cyc[0] - a_start_cyc, A_LEAD + 2);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (a_wr_cyc[k] - a_wr_cyc[k-1] != int'(A_GAP)) begin
                    errors++;
                    $display("FAIL basic_period%0d: got %0d, required %0d", k, a_wr_cyc[k] - a_wr_cyc[k-1], A_GAP);
                end
            end
        end
        checks++;
        if (a_done_cnt != 1 || a_done_cyc != a_fall_cyc) begin
            errors++;
            $display("FAIL basic_done: got count=%0d at %0d, required 1 at %0d", a_done_cnt, a_done_cyc, a_fall_cyc);
        end
        checks++;
        if (a_dl_cnt != int'(A_LEAD + 4 * A_GAP + A_TAIL)) begin
            errors++;
            $display("FAIL basic_window: got %0d, required %0d", a_dl_cnt, A_LEAD + 4 * A_GAP + A_TAIL);
        end
        checks++;
        if ({a_addr, a_data, a_busy} !== {22'd3, 8'hD4, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: got addr=%0h data=%02h busy=%b, required 3 d4 0", a_addr, a_data, a_busy);
        end
    endtask

    task automatic test_zero_length();
        clear_a();
        drive_a(0, -1, 0, -1, 1'b1);
        checks++;
        if (a_wr_cnt != 0 || a_ready_cnt != 0) begin
            errors++;
            $display("FAIL zero_activity: got wr=%0d ready=%0d, required 0 0", a_wr_cnt, a_ready_cnt);
        end
        checks++;
        if (a_done_cnt != 1) begin errors++; $display("FAIL zero_done: got %0d, required 1", a_done_cnt); end
        checks++;
        if (a_dl_cnt != int'(A_LEAD + A_TAIL)) begin
            errors++;
            $display("FAIL zero_window: got %0d, required %0d", a_dl_cnt, A_LEAD + A_TAIL);
        end
    endtask

    task automatic test_stall();
        clear_a();
        a_src[0] = 8'h3C; a_src[1] = 8'h5A; a_src[2] = 8'h96;
        drive_a(3, 1, 20, -1, 1'b0);
        checks++;
        if (a_wr_cnt != 3 || a_exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_wr_count: got %0d pending %0d, required 3 pending 0", a_wr_cnt, a_exp_q.size());
        end
        if (a_wr_cyc.size() == 3) begin
            checks++;
            if (a_wr_cyc[1] - a_wr_cyc[0] != 21 || a_wr_cyc[2] - a_wr_cyc[1] != int'(A_GAP)) begin
                errors++;
                $display("FAIL stall_spacing: got %0d,%0d, required 21,%0d",
                         a_wr_cyc[1] - a_wr_cyc[0], a_wr_cyc[2] - a_wr_cyc[1], A_GAP);
            end
        end
        checks++;
        if (a_fall_cnt != 1) begin errors++; $display("FAIL stall_window: got %0d falls, required 1", a_fall_cnt); end
    endtask

    task automatic test_abort();
        clear_a();
        a_src[0] = 8'hE0; a_src[1] = 8'hE1; a_src[2] = 8'hE2; a_src[3] = 8'hE3; a_src[4] = 8'hE4;
        drive_a(5, -1, 0, 2, 1'b0);
        checks++;
        if (a_wr_cnt != 2) begin errors++; $display("FAIL abort_wr_count: got %0d, required 2", a_wr_cnt); end
        checks++;
        if ({a_addr, a_data} !== {22'd1, 8'hE1}) begin
            errors++;
            $display("FAIL abort_hold: got addr=%0h data=%02h, required 1 e1", a_addr, a_data);
        end
        checks++;
        if (a_done_cnt != 1 || a_fall_cyc != a_abort_cyc + 1 + int'(A_TAIL)) begin
            errors++;
            $display("FAIL abort_tail: got done=%0d fall_after=%0d, required 1 %0d",
                     a_done_cnt, a_fall_cyc - a_abort_cyc - 1, A_TAIL);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        clear_a();
        a_exp_q.push_back({22'd0, 8'h55});
        @(posedge clk); #1;
        a_start = 1'b1; a_length = 22'd4;
        @(posedge clk); #1;
        a_start = 1'b0; a_s_valid = 1'b1; a_s_data = 8'h55;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            if (a_wr) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_timeout: no write, required one within 200 cycles"); end
        @(posedge clk); #1;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_downloading, a_addr, a_data, a_wr, a_busy, a_done, a_s_ready} !== 36'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: dl=%b addr=%0h data=%02h wr=%b busy=%b done=%b rdy=%b, required all 0",
                     a_downloading, a_addr, a_data, a_wr, a_busy, a_done, a_s_ready);
        end
        a_rst_n = 1'b1; a_s_valid = 1'b0;
        clear_a();
        a_src[0] = 8'h11; a_src[1] = 8'h22;
        drive_a(2, -1, 0, -1, 1'b0);
        checks++;
        if (a_wr_cnt != 2 || {a_addr, a_data} !== {22'd1, 8'h22}) begin
            errors++;
            $display("FAIL rstmid_restart: got wr=%0d addr=%0h data=%02h, required 2 1 22", a_wr_cnt, a_addr, a_data);
        end
    endtask

    task automatic test_back_to_back();
        int i = 0;
        bit fin = 0;
        bit restarted = 0;
        clear_b();
        b_src[0] = 8'h10; b_src[1] = 8'h20; b_src[2] = 8'h30;
        @(posedge clk); #1;
        b_start = 1'b1; b_length = 22'd3; b_start_cyc = cyc;
        for (int c = 0; c < 500 && !fin; c++) begin
            @(posedge clk); #1;
            b_start = 1'b0; b_s_valid = 1'b0;
            if (b_done) begin
                fin = 1; b_start = 1'b1; b_length = 22'd1;
            end else begin
                if (b_wr_cnt == 1 && !restarted) begin b_start = 1'b1; b_length = 22'd7; restarted = 1; end
                if (i < 3) begin
                    b_s_valid = 1'b1; b_s_data = b_src[i];
                    #1;
                    if (b_s_ready) begin b_exp_q.push_back({22'(i), b_src[i]}); i++; end
                end
            end
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL b2b_timeout: done not seen, required within 500 cycles"); end
        @(posedge clk); #1;
        b_start = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_downloading !== 1'b1) begin
            errors++;
            $display("FAIL done_restart: got busy=%b dl=%b, required 1 1", b_busy, b_downloading);
        end
        checks++;
        if (b_wr_cnt != 3 || b_done_cnt != 1) begin
            errors++;
            $display("FAIL b2b_counts: got wr=%0d done=%0d, required 3 1", b_wr_cnt, b_done_cnt);
        end
        if (b_wr_cyc.size() == 3) begin
            checks++;
            if (b_wr_cyc[0] != b_start_cyc + int'(B_LEAD) + 2 ||
                b_wr_cyc[1] - b_wr_cyc[0] != int'(B_GAP) || b_wr_cyc[2] - b_wr_cyc[1] != int'(B_GAP)) begin
                errors++;
                $display("FAIL b2b_timing: got lat=%0d p=%0d,%0d, required %0d p=%0d,%0d",
                         b_wr_cyc[0] - b_start_cyc, b_wr_cyc[1] - b_wr_cyc[0], b_wr_cyc[2] - b_wr_cyc[1],
                         B_LEAD + 2, B_GAP, B_GAP);
            end
        end
        checks++;
        if (b_dl_cnt != int'(B_LEAD + 3 * B_GAP + B_TAIL)) begin
            errors++;
            $display("FAIL b2b_window: got %0d, required %0d", b_dl_cnt, B_LEAD + 3 * B_GAP + B_TAIL);
        end
        fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(posedge clk); #1;
            b_s_valid = 1'b0;
            if (b_done) fin = 1;
            else if (b_exp_q.size() == 0 && b_wr_cnt == 3) begin
                b_s_valid = 1'b1; b_s_data = 8'h5A;
                #1;
                if (b_s_ready) b_exp_q.push_back({22'd0, 8'h5A});
            end
        end
        b_s_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (!fin || b_wr_cnt != 4 || b_exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_transfer: got done=%0d wr=%0d pending=%0d, required 1 4 0",
                     fin, b_wr_cnt, b_exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
